stopwatch_lap: RTL

Parametrised successor to the six-digit BCD stopwatch core. It adds:
- a configurable tick prescaler, so the block runs from any system clock;
- count-up and count-down (timer) direction;
- preset load;
- lap/split capture with display hold;
- selectable wrap or saturate at full scale.

It sits between the board's button debouncers and the 7-segment display driver, and presents one 4-bit BCD code per digit.

---
 rtl/stopwatch_lap.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/stopwatch_lap.sv
// Six-digit BCD stopwatch/timer with tick prescaler, preset load, lap hold and
// wrap-or-saturate at 99:59.99. Digit outputs are combinational from registers.
module stopwatch_lap #(
  parameter int unsigned TICK_DIV   = 1,
  parameter bit          WRAP       = 1'b1,
  parameter logic [3:0]  BLANK_CODE = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mode,
  input  logic        dir,
  input  logic        load,
  input  logic [23:0] preset,
  input  logic        lap,
  output logic [3:0]  timer10ms,
  output logic [3:0]  timer100ms,
  output logic [3:0]  timer1sec,
  output logic [3:0]  timer10sec,
  output logic [3:0]  timer1min,
  output logic [3:0]  timer10min,
  output logic        done,
  output logic        overflow,
  output logic        lap_active
);

  localparam int unsigned PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned NDIG       = 6;
  localparam logic [23:0] FULL_SCALE = 24'h995999;

  logic [PW-1:0] pre_q;
  logic [23:0]   count_q;
  logic [23:0]   lap_q;
  logic [23:0]   count_inc;
  logic [23:0]   count_dec;
  logic [23:0]   preset_clamped;
  logic [23:0]   disp;
  logic [3:0]    d;
  logic          carry;
  logic          borrow;
  logic          tick;
  logic          at_max;
  logic          at_zero;

  // The 10sec digit (index 3) rolls at 5; every other digit rolls at 9.
  function automatic logic [3:0] digit_max(input int unsigned i);
    return (i == 3) ? 4'd5 : 4'd9;
  endfunction

  assign tick    = enable && (pre_q == PW'(TICK_DIV - 1));
  assign at_max  = (count_q == FULL_SCALE);
  assign at_zero = (count_q == 24'h000000);

  // Ripple increment/decrement and per-digit preset clamp, index 0 = 10ms.
  always_comb begin
    count_inc      = count_q;
    count_dec      = count_q;
    preset_clamped = preset;
    carry          = 1'b1;
    borrow         = 1'b1;
    d              = 4'd0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      d = count_q[4*i +: 4];
      if (carry) begin
        if (d >= digit_max(i)) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = d + 4'd1;
          carry               = 1'b0;
        end
      end
      if (borrow) begin
        if (d == 4'd0) begin
          count_dec[4*i +: 4] = digit_max(i);
        end else begin
          count_dec[4*i +: 4] = d - 4'd1;
          borrow              = 1'b0;
        end
      end
      if (preset[4*i +: 4] > digit_max(i)) begin
        preset_clamped[4*i +: 4] = digit_max(i);
      end
    end
  end

  // Prescaler, count and sticky flags; load takes priority over a tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q    <= '0;
      count_q  <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      pre_q    <= '0;
      count_q  <= preset_clamped;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else if (enable) begin
      if (tick) begin
        pre_q <= '0;
        if (!dir) begin
          if (!at_max) begin
            count_q <= count_inc;
          end else if (WRAP) begin
            count_q <= '0;
          end else begin
            overflow <= 1'b1;
          end
        end else begin
          if (at_zero) begin
            done <= 1'b1;
          end else begin
            count_q <= count_dec;
            if (count_dec == 24'h000000) done <= 1'b1;
          end
        end
      end else begin
        pre_q <= pre_q + PW'(1);
      end
    end
  end

  // Lap toggles the display hold; capture takes the pre-tick, pre-load count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lap_q      <= '0;
      lap_active <= 1'b0;
    end else if (lap) begin
      if (!lap_active) begin
        lap_q      <= count_q;
        lap_active <= 1'b1;
      end else begin
        lap_active <= 1'b0;
      end
    end
  end

  always_comb begin
    if (!mode) begin
      disp = {NDIG{BLANK_CODE}};
    end else if (lap_active) begin
      disp = lap_q;
    end else begin
      disp = count_q;
    end
  end

  assign timer10ms  = disp[3:0];
  assign timer100ms = disp[7:4];
  assign timer1sec  = disp[11:8];
  assign timer10sec = disp[15:12];
  assign timer1min  = disp[19:16];
  assign timer10min = disp[23:20];

endmodule
